// File: rtl/scheduler_acc_lookup_pkg.sv
// Shared OmpSs manager constants: table depth, scheduling-data field positions
// and the lookup FSM encoding.
package scheduler_acc_lookup_pkg;
  localparam int MAX_ACCS = 16;
  localparam int ACC_BITS = $clog2(MAX_ACCS);

  localparam int SCHED_DATA_ACCID_L     = 0;
  localparam int SCHED_DATA_COUNT_L     = 8;
  localparam int SCHED_DATA_TASK_TYPE_L = 16;
  localparam int SCHED_DATA_TASK_TYPE_H = 49;
  localparam int SCHED_DATA_W           = SCHED_DATA_TASK_TYPE_H + 1;
  localparam int TASK_W = SCHED_DATA_TASK_TYPE_H - SCHED_DATA_TASK_TYPE_L + 1;

  localparam logic [ACC_BITS-1:0] INS_NUM_ANY = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COMPARE,
    S_RESPOND
  } state_t;
endpackage

// File: rtl/scheduler_rr_table.sv
// Per-table-index round-robin counters; the selected counter wraps to zero
// after reaching the entry's instance count.
module scheduler_rr_table #(
  parameter int DEPTH = scheduler_acc_lookup_pkg::MAX_ACCS,
  parameter int W     = scheduler_acc_lookup_pkg::ACC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] idx,
  input  logic         we,
  input  logic [W-1:0] count,
  output logic [W-1:0] rr_val
);
  logic [W-1:0] rr_q [DEPTH];
  logic [W-1:0] rr_d [DEPTH];

  assign rr_val = rr_q[idx];

  always_comb begin
    rr_d = rr_q;
    if (we) begin
      rr_d[idx] = (rr_q[idx] == count) ? '0 : rr_q[idx] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rr_q[i] <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
endmodule

// File: rtl/scheduler_acc_lookup.sv
// Scans the scheduling-data table for a task type and resolves a concrete
// accelerator ID, either the requested instance or the next round-robin one.
module scheduler_acc_lookup
  import scheduler_acc_lookup_pkg::*;
#(
  parameter int MAX_ACCS = scheduler_acc_lookup_pkg::MAX_ACCS,
  parameter int ACC_BITS = $clog2(MAX_ACCS)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [ACC_BITS:0]       num_entries,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [TASK_W-1:0]       req_task_type,
  input  logic [ACC_BITS-1:0]     req_ins_num,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_found,
  output logic [ACC_BITS-1:0]     rsp_acc_id,
  output logic [ACC_BITS-1:0]     scheduleData_address0,
  output logic                    scheduleData_ce0,
  input  logic [SCHED_DATA_W-1:0] scheduleData_q0,
  output state_t                  dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable until that edge.
  state_t              state_q, state_d;
  logic [ACC_BITS-1:0] idx_q, idx_d;
  logic [TASK_W-1:0]   task_q, task_d;
  logic [ACC_BITS-1:0] ins_q, ins_d;
  logic                found_q, found_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;

  logic [ACC_BITS-1:0] entry_accid, entry_count, rr_val;
  logic [TASK_W-1:0]   entry_type;
  logic                rr_we, is_last;
  logic                unused_q0;

  assign entry_accid = scheduleData_q0[SCHED_DATA_ACCID_L +: ACC_BITS];
  assign entry_count = scheduleData_q0[SCHED_DATA_COUNT_L +: ACC_BITS];
  assign entry_type  = scheduleData_q0[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
  // Padding bits between the narrow ID fields carry no information.
  assign unused_q0   = ^scheduleData_q0;
  assign is_last     = ({1'b0, idx_q} == (num_entries - 1'b1));

  scheduler_rr_table #(
    .DEPTH(MAX_ACCS),
    .W    (ACC_BITS)
  ) u_rr (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .idx   (idx_q),
    .we    (rr_we),
    .count (entry_count),
    .rr_val(rr_val)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    task_d  = task_q;
    ins_d   = ins_q;
    found_d = found_q;
    acc_d   = acc_q;
    rr_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          task_d = req_task_type;
          ins_d  = req_ins_num;
          if (num_entries == '0) begin
            found_d = 1'b0;
            acc_d   = '0;
            state_d = S_RESPOND;
          end else begin
            // idx doubles as the read address, so it only moves on entry to ISSUE.
            idx_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_COMPARE;
      S_COMPARE: begin
        if (entry_type == task_q) begin
          state_d = S_RESPOND;
          if (ins_q == ACC_BITS'(INS_NUM_ANY)) begin
            acc_d   = entry_accid + rr_val;
            found_d = 1'b1;
            rr_we   = 1'b1;
          end else if (ins_q > entry_count) begin
            acc_d   = '0;
            found_d = 1'b0;
          end else begin
            acc_d   = entry_accid + ins_q;
            found_d = 1'b1;
          end
        end else if (is_last) begin
          acc_d   = '0;
          found_d = 1'b0;
          state_d = S_RESPOND;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_RESPOND: if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      task_q  <= '0;
      ins_q   <= '0;
      found_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      task_q  <= task_d;
      ins_q   <= ins_d;
      found_q <= found_d;
      acc_q   <= acc_d;
    end
  end

  assign req_ready             = (state_q == S_IDLE);
  assign rsp_valid             = (state_q == S_RESPOND);
  assign scheduleData_ce0      = (state_q == S_ISSUE);
  assign scheduleData_address0 = idx_q;
  assign rsp_found             = found_q;
  assign rsp_acc_id            = acc_q;
  assign dbg_state             = state_q;
endmodule

// File: tb/tb_scheduler_acc_lookup.sv
// Bench for scheduler_acc_lookup: BRAM model, request driver, expected-response
// queue and end-of-run report.
module tb_scheduler_acc_lookup;
  import scheduler_acc_lookup_pkg::*;

  logic                    clk = 1'b0;
  logic                    ap_rst;
  logic [ACC_BITS:0]       num_entries;
  logic                    req_valid, req_ready;
  logic [TASK_W-1:0]       req_task_type;
  logic [ACC_BITS-1:0]     req_ins_num;
  logic                    rsp_valid, rsp_ready, rsp_found;
  logic [ACC_BITS-1:0]     rsp_acc_id;
  logic [ACC_BITS-1:0]     sd_addr;
  logic                    sd_ce;
  logic [SCHED_DATA_W-1:0] sd_q;
  state_t                  dbg_state;

  logic [SCHED_DATA_W-1:0] mem [MAX_ACCS];
  logic [12:0]             exp_q [$];
  int checks = 0;
  int failures = 0;
  int ce_cnt = 0;

  scheduler_acc_lookup dut (
    .ap_clk               (clk),
    .ap_rst               (ap_rst),
    .num_entries          (num_entries),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_task_type        (req_task_type),
    .req_ins_num          (req_ins_num),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_found            (rsp_found),
    .rsp_acc_id           (rsp_acc_id),
    .scheduleData_address0(sd_addr),
    .scheduleData_ce0     (sd_ce),
    .scheduleData_q0      (sd_q),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM model ----------------
  always @(posedge clk) begin
    if (sd_ce) begin
      sd_q <= mem[sd_addr];
      ce_cnt++;
    end
  end

  function automatic logic [SCHED_DATA_W-1:0] mk_entry(input logic [TASK_W-1:0] t,
      input logic [ACC_BITS-1:0] accid, input logic [ACC_BITS-1:0] count);
    logic [SCHED_DATA_W-1:0] e;
    e = '0;
    e[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L] = t;
    e[SCHED_DATA_ACCID_L +: ACC_BITS] = accid;
    e[SCHED_DATA_COUNT_L +: ACC_BITS] = count;
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  // Called at posedge+1. Latency counts rising edges from the handshake edge
  // (cycle 0) to the first cycle with rsp_valid high.
  task automatic run_req(input string tag, input logic [TASK_W-1:0] t,
      input logic [ACC_BITS-1:0] ins, input logic exp_found,
      input logic [ACC_BITS-1:0] exp_acc, input int exp_lat, input int hold,
      input logic pend, input logic [TASK_W-1:0] pend_t);
    logic [12:0] e;
    int lat;
    int waited;
    exp_q.push_back({exp_found, exp_acc, 8'(exp_lat)});
    rsp_ready     = (hold == 0);
    req_valid     = 1'b1;
    req_task_type = t;
    req_ins_num   = ins;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_found"}, rsp_found, e[12]);
    check_eq({tag, "_acc_id"}, rsp_acc_id, e[11:8]);
    check_eq({tag, "_latency"}, lat, e[7:0]);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (pend && i == 2) begin
          req_valid     = 1'b1;
          req_task_type = pend_t;
          req_ins_num   = INS_NUM_ANY;
        end
        @(posedge clk); #1;
        check_eq({tag, "_hold_valid"}, rsp_valid, 1'b1);
        check_eq({tag, "_hold_acc"}, rsp_acc_id, e[11:8]);
        check_eq({tag, "_hold_req_ready"}, req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, "_released_idle"}, 32'(dbg_state), 32'(S_IDLE));
      check_eq({tag, "_released_no_rsp"}, rsp_valid, 1'b0);
    end else begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [ACC_BITS-1:0] ANY = INS_NUM_ANY;

  initial begin
    int ce_before;
    ap_rst        = 1'b1;
    req_valid     = 1'b0;
    rsp_ready     = 1'b1;
    req_task_type = '0;
    req_ins_num   = '0;
    num_entries   = 2;
    for (int i = 0; i < MAX_ACCS; i++) mem[i] = mk_entry(34'd0, 4'd0, 4'd0);
    mem[0] = mk_entry(34'd100, 4'd0, 4'd2);
    mem[1] = mk_entry(34'd200, 4'd3, 4'd0);
    mem[2] = mk_entry(34'd100, 4'd9, 4'd0);
    mem[3] = mk_entry(34'd300, 4'd7, 4'd1);

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_found", rsp_found, 1'b0);
    check_eq("rst_acc_id", rsp_acc_id, '0);
    check_eq("rst_ce0", sd_ce, 1'b0);
    check_eq("rst_addr", sd_addr, '0);
    check_eq("rst_req_ready", req_ready, 1'b1);
    ap_rst = 1'b0;
    @(posedge clk); #1;

    run_req("any100_a", 34'd100, ANY, 1'b1, 4'd0, 3, 0, 1'b0, '0);
    run_req("any100_b", 34'd100, ANY, 1'b1, 4'd1, 3, 0, 1'b0, '0);
    run_req("any100_c", 34'd100, ANY, 1'b1, 4'd2, 3, 0, 1'b0, '0);
    run_req("any100_d", 34'd100, ANY, 1'b1, 4'd0, 3, 0, 1'b0, '0);
    run_req("any200_a", 34'd200, ANY, 1'b1, 4'd3, 5, 0, 1'b0, '0);
    run_req("any200_b", 34'd200, ANY, 1'b1, 4'd3, 5, 0, 1'b0, '0);
    run_req("ins1_100", 34'd100, 4'd1, 1'b1, 4'd1, 3, 0, 1'b0, '0);
    run_req("any100_e", 34'd100, ANY, 1'b1, 4'd1, 3, 0, 1'b0, '0);
    run_req("ins3_100", 34'd100, 4'd3, 1'b0, 4'd0, 3, 0, 1'b0, '0);
    run_req("ins2_100", 34'd100, 4'd2, 1'b1, 4'd2, 3, 0, 1'b0, '0);
    run_req("miss999", 34'd999, ANY, 1'b0, 4'd0, 5, 0, 1'b0, '0);

    num_entries = 0;
    ce_before = ce_cnt;
    run_req("empty_tbl", 34'd100, ANY, 1'b0, 4'd0, 1, 0, 1'b0, '0);
    check_eq("empty_tbl_no_ce0", ce_cnt, ce_before);

    num_entries = 4;
    run_req("dup_first_wins", 34'd100, ANY, 1'b1, 4'd2, 3, 0, 1'b0, '0);
    run_req("any300_a", 34'd300, ANY, 1'b1, 4'd7, 9, 0, 1'b0, '0);
    run_req("any300_b", 34'd300, ANY, 1'b1, 4'd8, 9, 0, 1'b0, '0);
    run_req("miss_4ent", 34'd999, ANY, 1'b0, 4'd0, 9, 0, 1'b0, '0);

    run_req("stall100", 34'd100, ANY, 1'b1, 4'd0, 3, 10, 1'b1, 34'd200);
    run_req("pending200", 34'd200, ANY, 1'b1, 4'd3, 5, 0, 1'b0, '0);

    num_entries   = 2;
    req_valid     = 1'b1;
    req_task_type = 34'd200;
    req_ins_num   = ANY;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("scan_ce0", sd_ce, 1'b1);
    check_eq("scan_addr", sd_addr, 4'd1);
    ap_rst = 1'b1;
    #1;
    check_eq("midrst_ce0", sd_ce, 1'b0);
    check_eq("midrst_addr", sd_addr, '0);
    check_eq("midrst_rsp_valid", rsp_valid, 1'b0);
    check_eq("midrst_found", rsp_found, 1'b0);
    check_eq("midrst_acc_id", rsp_acc_id, '0);
    check_eq("midrst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    ap_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midrst_lost_rsp", rsp_valid, 1'b0);
    run_req("post_rst_any100", 34'd100, ANY, 1'b1, 4'd0, 3, 0, 1'b0, '0);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
